// File: rtl/mux_arbiter_2to1.sv
// ---------------------------------------------------------------------------
// mux_arbiter_2to1
//
// Purpose:
//    Packet-aware round-robin arbiter that merges two valid/ready beat streams
//    onto a single registered output stream. A requester keeps the grant for a
//    whole packet (until its last beat) or until MAX_BURST beats have been
//    accepted, whichever comes first. After every grant the arbiter spends one
//    cycle in IDLE before granting again. When both requesters are waiting in
//    IDLE, the one that did not hold the previous grant wins.
//
// Parameters:
//    DATA_WIDTH - width of one data beat
//    MAX_BURST  - maximum beats accepted per grant (1..256)
//
// Ports:
//    clk                  - single clock, all state on the rising edge
//    reset                - asynchronous, active-high reset
//    in0_valid/in1_valid  - requester k presents a beat
//    in0_data/in1_data    - requester k beat data
//    in0_last/in1_last    - final beat of requester k packet
//    in0_ready/in1_ready  - requester k beat accepted this cycle (with valid)
//    out_valid            - registered output beat valid
//    out_data             - registered output beat
//    out_last             - registered copy of the accepted last flag
//    out_src              - requester index that produced the output beat
//    out_ready            - downstream accepts the beat (with out_valid)
//    sel                  - current grant, drives the shared 2:1 data mux
// ---------------------------------------------------------------------------
module mux_arbiter_2to1 #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in0_valid,
    input  logic [DATA_WIDTH-1:0] in0_data,
    input  logic                  in0_last,
    output logic                  in0_ready,
    input  logic                  in1_valid,
    input  logic [DATA_WIDTH-1:0] in1_data,
    input  logic                  in1_last,
    output logic                  in1_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  out_src,
    input  logic                  out_ready,
    output logic                  sel
);

    localparam int               CNT_W       = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               sel_q, sel_d;
    logic               lastGrant_q, lastGrant_d;
    logic [CNT_W-1:0]   beatCount_q, beatCount_d;
    logic               outValid_q, outValid_d;
    logic [DATA_WIDTH-1:0] outData_q, outData_d;
    logic               outLast_q, outLast_d;
    logic               outSrc_q, outSrc_d;

    logic               outSpace;
    logic               grantValid;
    logic               grantLast;
    logic               handshake;
    logic [CNT_W-1:0]   beatCountInc;

    // The output register can take a new beat when it is empty or its
    // current beat leaves this cycle; this is what keeps a grant running at
    // one beat per cycle under continuous out_ready.
    assign outSpace     = !outValid_q || out_ready;

    // sel always equals the granted index while in a GRANT state, so the
    // granted requester's signals are simply picked through the sel mux.
    assign grantValid   = sel_q ? in1_valid : in0_valid;
    assign grantLast    = sel_q ? in1_last  : in0_last;
    assign beatCountInc = beatCount_q + CNT_W'(1);

    assign in0_ready    = (state_q == GRANT0) && outSpace;
    assign in1_ready    = (state_q == GRANT1) && outSpace;
    assign handshake    = (state_q != IDLE) && grantValid && outSpace;

    // Arbitration and grant tracking. In IDLE a waiting requester is granted
    // on the next edge; with both waiting, the one not granted last time wins.
    // A grant ends on the handshake carrying last, or on the handshake that
    // brings the burst count to MAX_BURST (the packet then continues under a
    // later grant, out_last untouched).
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        lastGrant_d = lastGrant_q;
        beatCount_d = beatCount_q;
        case (state_q)
            IDLE: begin
                if (in0_valid && (!in1_valid || lastGrant_q)) begin
                    state_d     = GRANT0;
                    sel_d       = 1'b0;
                    beatCount_d = '0;
                end else if (in1_valid) begin
                    state_d     = GRANT1;
                    sel_d       = 1'b1;
                    beatCount_d = '0;
                end
            end
            GRANT0, GRANT1: begin
                if (handshake) begin
                    beatCount_d = beatCountInc;
                    if (grantLast || (beatCountInc == BURST_LIMIT)) begin
                        state_d     = IDLE;
                        lastGrant_d = sel_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output register. A new beat overwrites the register only when there is
    // space, so a stalled beat stays stable until the downstream takes it.
    always_comb begin
        outValid_d = outValid_q;
        outData_d  = outData_q;
        outLast_d  = outLast_q;
        outSrc_d   = outSrc_q;
        if (handshake) begin
            outValid_d = 1'b1;
            outData_d  = sel_q ? in1_data : in0_data;
            outLast_d  = grantLast;
            outSrc_d   = sel_q;
        end else if (out_ready) begin
            outValid_d = 1'b0;
        end
    end

    // State registers. Reset drops any packet in flight, including a beat
    // waiting in the output register, and leaves last-grant pointing at
    // requester 1 so requester 0 wins the first simultaneous request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sel_q       <= 1'b0;
            lastGrant_q <= 1'b1;
            beatCount_q <= '0;
            outValid_q  <= 1'b0;
            outData_q   <= '0;
            outLast_q   <= 1'b0;
            outSrc_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            lastGrant_q <= lastGrant_d;
            beatCount_q <= beatCount_d;
            outValid_q  <= outValid_d;
            outData_q   <= outData_d;
            outLast_q   <= outLast_d;
            outSrc_q    <= outSrc_d;
        end
    end

    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign out_last  = outLast_q;
    assign out_src   = outSrc_q;
    assign sel       = sel_q;

endmodule

// File: tb/tb_mux_arbiter_2to1.sv
// ---------------------------------------------------------------------------
// tb_mux_arbiter_2to1
//
// Purpose:
//    Self-checking bench for mux_arbiter_2to1. A behavioural model of the
//    arbiter (grant owner, burst count, output beat) predicts every output on
//    every cycle, and a scoreboard of accepted input beats checks that the
//    output stream carries each beat exactly once, in acceptance order.
//    Directed sequences with hand-computed expectations cover the basic
//    round-robin packet flow, forced burst release, reset mid-packet, and a
//    second instance with MAX_BURST=1.
// ---------------------------------------------------------------------------
module tb_mux_arbiter_2to1;

    localparam int DW   = 16;
    localparam int MAXB = 4;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct packed {
        logic          src;
        logic          last;
        logic [DW-1:0] data;
    } sbEntry_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in0_valid = 1'b0, in1_valid = 1'b0;
    logic [DW-1:0] in0_data = '0, in1_data = '0;
    logic          in0_last = 1'b0, in1_last = 1'b0;
    logic          in0_ready, in1_ready;
    logic          out_valid, out_last, out_src, sel;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;

    // Second instance, MAX_BURST = 1, driven by constant requests
    logic          bReset = 1'b1;
    logic          bIn0Ready, bIn1Ready, bOutValid, bOutLast, bOutSrc, bSel;
    logic [DW-1:0] bOutData;

    beat_t    q0[$];
    beat_t    q1[$];
    sbEntry_t sbQ[$];
    int       seq0 = 0, seq1 = 0;
    bit       randomMode = 1'b0;
    bit       autoGen = 1'b0;
    int       expCode[$];

    int checkCount = 0;
    int errCount   = 0;

    always #5 clk = ~clk;

    mux_arbiter_2to1 #(.DATA_WIDTH(DW), .MAX_BURST(MAXB)) dut (
        .clk(clk), .reset(reset),
        .in0_valid(in0_valid), .in0_data(in0_data), .in0_last(in0_last), .in0_ready(in0_ready),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(in1_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_src(out_src),
        .out_ready(out_ready), .sel(sel)
    );

    mux_arbiter_2to1 #(.DATA_WIDTH(DW), .MAX_BURST(1)) dutBurst1 (
        .clk(clk), .reset(bReset),
        .in0_valid(1'b1), .in0_data(16'hB0B0), .in0_last(1'b0), .in0_ready(bIn0Ready),
        .in1_valid(1'b1), .in1_data(16'hB0B1), .in1_last(1'b0), .in1_ready(bIn1Ready),
        .out_valid(bOutValid), .out_data(bOutData), .out_last(bOutLast), .out_src(bOutSrc),
        .out_ready(1'b1), .sel(bSel)
    );

    // Single comparison point: every check bumps checkCount, failures bump
    // errCount and print one line.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // ----------------------------------------------------------------------
    // Behavioural model: who owns the grant (-1 = nobody), how many beats the
    // current grant has taken, who was granted last, and what beat the output
    // register should hold.
    // ----------------------------------------------------------------------
    int            mOwner;
    int            mLast;
    int            mBeats;
    logic          mSel;
    logic          mOutValid;
    logic [DW-1:0] mOutData;
    logic          mOutLast;
    logic          mOutSrc;
    logic          expRdy0, expRdy1, mHs0, mHs1;
    int            idleWinner;

    assign expRdy0    = (mOwner == 0) && (!mOutValid || out_ready);
    assign expRdy1    = (mOwner == 1) && (!mOutValid || out_ready);
    assign mHs0       = in0_valid && expRdy0;
    assign mHs1       = in1_valid && expRdy1;
    assign idleWinner = (in0_valid && in1_valid) ? (1 - mLast) : (in0_valid ? 0 : 1);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mOwner    <= -1;
            mLast     <= 1;
            mBeats    <= 0;
            mSel      <= 1'b0;
            mOutValid <= 1'b0;
            mOutData  <= '0;
            mOutLast  <= 1'b0;
            mOutSrc   <= 1'b0;
        end else begin
            if (mOwner < 0) begin
                if (in0_valid || in1_valid) begin
                    mOwner <= idleWinner;
                    mSel   <= (idleWinner == 1);
                    mBeats <= 0;
                end
            end else if (mHs0 || mHs1) begin
                mBeats <= mBeats + 1;
                if ((mHs0 ? in0_last : in1_last) || (mBeats + 1 == MAXB)) begin
                    mOwner <= -1;
                    mLast  <= mOwner;
                end
            end
            if (mHs0 || mHs1) begin
                mOutValid <= 1'b1;
                mOutData  <= mHs0 ? in0_data : in1_data;
                mOutLast  <= mHs0 ? in0_last : in1_last;
                mOutSrc   <= mHs1;
            end else if (out_ready) begin
                mOutValid <= 1'b0;
            end
        end
    end

    // ----------------------------------------------------------------------
    // Compare process: model vs DUT every cycle, backpressure stability and
    // the beat scoreboard, all sampled on the falling edge.
    // ----------------------------------------------------------------------
    logic          holdValid = 1'b0;
    logic [DW-1:0] holdData  = '0;
    logic          holdLast  = 1'b0;
    logic          holdSrc   = 1'b0;

    always @(negedge clk) begin
        sbEntry_t e;
        checkOutput("in0_ready", in0_ready, expRdy0);
        checkOutput("in1_ready", in1_ready, expRdy1);
        checkOutput("sel", sel, mSel);
        checkOutput("out_valid", out_valid, mOutValid);
        if (mOutValid) begin
            checkOutput("out_data", out_data, mOutData);
            checkOutput("out_last", out_last, mOutLast);
            checkOutput("out_src", out_src, mOutSrc);
        end
        if (holdValid && !reset) begin
            checkOutput("hold_valid", out_valid, 1'b1);
            checkOutput("hold_data", out_data, holdData);
            checkOutput("hold_last", out_last, holdLast);
            checkOutput("hold_src", out_src, holdSrc);
        end
        if (out_valid === 1'b1 && out_ready && !reset) begin
            checkOutput("sb_not_empty", sbQ.size() != 0, 1'b1);
            if (sbQ.size() != 0) begin
                e = sbQ.pop_front();
                checkOutput("sb_beat", {out_src, out_last, out_data}, e);
            end
        end
        holdValid <= out_valid && !out_ready && !reset;
        holdData  <= out_data;
        holdLast  <= out_last;
        holdSrc   <= out_src;
    end

    // ----------------------------------------------------------------------
    // Stimulus helpers
    // ----------------------------------------------------------------------
    task automatic pushPacket(input bit src, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.last = (i == len - 1);
            if (src) begin
                b.data = {1'b1, seq1[14:0]};
                seq1++;
                q1.push_back(b);
            end else begin
                b.data = {1'b0, seq0[14:0]};
                seq0++;
                q0.push_back(b);
            end
        end
    endtask

    task automatic driveInputs();
        in0_valid = 1'b0; in0_data = '0; in0_last = 1'b0;
        in1_valid = 1'b0; in1_data = '0; in1_last = 1'b0;
        if (q0.size() != 0) begin
            in0_valid = !randomMode || ($urandom_range(0, 3) != 0);
            in0_data  = q0[0].data;
            in0_last  = q0[0].last;
        end
        if (q1.size() != 0) begin
            in1_valid = !randomMode || ($urandom_range(0, 3) != 0);
            in1_data  = q1[0].data;
            in1_last  = q1[0].last;
        end
        out_ready = !randomMode || ($urandom_range(0, 2) != 0);
    endtask

    // One clock cycle: note accepted beats before the edge, then present the
    // next inputs just after it.
    task automatic applyStimulus();
        sbEntry_t e;
        @(negedge clk);
        if (in0_valid && in0_ready === 1'b1) begin
            e.src = 1'b0; e.last = in0_last; e.data = in0_data;
            sbQ.push_back(e);
            void'(q0.pop_front());
        end
        if (in1_valid && in1_ready === 1'b1) begin
            e.src = 1'b1; e.last = in1_last; e.data = in1_data;
            sbQ.push_back(e);
            void'(q1.pop_front());
        end
        @(posedge clk);
        #1;
        if (autoGen) begin
            if (q0.size() == 0 && $urandom_range(0, 2) == 0) pushPacket(1'b0, $urandom_range(1, 6));
            if (q1.size() == 0 && $urandom_range(0, 2) == 0) pushPacket(1'b1, $urandom_range(1, 6));
        end
        driveInputs();
    endtask

    // Runs steps and compares each cycle's output against expCode:
    // -1 = no output beat, otherwise out_src*2 + out_last.
    task automatic runDirected(input string name, input int steps);
        int code;
        for (int i = 0; i < steps; i++) begin
            applyStimulus();
            code = (out_valid === 1'b1) ? (int'(out_src) * 2 + int'(out_last)) : -1;
            checkOutput($sformatf("%s_step%0d", name, i + 1), code, expCode[i]);
        end
        expCode.delete();
    endtask

    // ----------------------------------------------------------------------
    // Main sequence
    // ----------------------------------------------------------------------
    initial begin
        int bSelExp[8];
        int bCodeExp[8];
        int code;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_sel", sel, 1'b0);
        checkOutput("rst_out_data", out_data, 16'h0);
        checkOutput("rst_out_last", out_last, 1'b0);
        checkOutput("rst_out_src", out_src, 1'b0);
        checkOutput("rst_in0_ready", in0_ready, 1'b0);

        // Both requesters with 3-beat packets: in0 first, one idle, then in1
        pushPacket(1'b0, 3);
        pushPacket(1'b1, 3);
        driveInputs();
        reset = 1'b0;
        expCode = '{-1, 0, 0, 1, -1, 2, 2, 3};
        runDirected("rr3", 8);

        // 6-beat in0 packet split by the 4-beat burst limit around in1
        pushPacket(1'b0, 6);
        pushPacket(1'b1, 1);
        driveInputs();
        expCode = '{-1, 0, 0, 0, 0, -1, 3, -1, 0, 1};
        runDirected("burst", 10);

        // in1 packet interrupted by reset right after its second beat
        pushPacket(1'b1, 4);
        driveInputs();
        expCode = '{-1, 2, 2};
        runDirected("prereset", 3);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midrst_out_valid", out_valid, 1'b0);
        checkOutput("midrst_sel", sel, 1'b0);
        checkOutput("midrst_in1_ready", in1_ready, 1'b0);
        checkOutput("midrst_out_data", out_data, 16'h0);
        q0.delete();
        q1.delete();
        sbQ.delete();
        pushPacket(1'b0, 2);
        pushPacket(1'b1, 2);
        driveInputs();
        @(posedge clk);
        #2;
        reset = 1'b0;
        applyStimulus();
        checkOutput("postrst_sel", sel, 1'b0);
        checkOutput("postrst_in0_ready", in0_ready, 1'b1);
        checkOutput("postrst_in1_ready", in1_ready, 1'b0);
        expCode = '{0, 1, -1, 2, 3};
        runDirected("postrst", 5);

        // Randomized traffic, valid gaps and backpressure
        randomMode = 1'b1;
        autoGen    = 1'b1;
        for (int i = 0; i < 3000; i++) applyStimulus();

        // Drain everything still queued
        randomMode = 1'b0;
        autoGen    = 1'b0;
        driveInputs();
        for (int i = 0; i < 60; i++) applyStimulus();
        checkOutput("drain_q0", q0.size(), 0);
        checkOutput("drain_q1", q1.size(), 0);
        checkOutput("drain_sb", sbQ.size(), 0);

        // MAX_BURST=1 instance: strict alternation with an idle between beats
        bSelExp  = '{0, 0, 1, 1, 0, 0, 1, 1};
        bCodeExp = '{-1, 0, -1, 2, -1, 0, -1, 2};
        bReset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            code = (bOutValid === 1'b1) ? (int'(bOutSrc) * 2 + int'(bOutLast)) : -1;
            checkOutput($sformatf("b1_sel%0d", i + 1), bSel, bSelExp[i]);
            checkOutput($sformatf("b1_out%0d", i + 1), code, bCodeExp[i]);
            checkOutput($sformatf("b1_rdy0_%0d", i + 1), bIn0Ready, (bCodeExp[i] == -1) && (bSelExp[i] == 0));
            checkOutput($sformatf("b1_rdy1_%0d", i + 1), bIn1Ready, (bCodeExp[i] == -1) && (bSelExp[i] == 1));
            if (bCodeExp[i] >= 0)
                checkOutput($sformatf("b1_data%0d", i + 1), bOutData, (bCodeExp[i] == 2) ? 16'hB0B1 : 16'hB0B0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, errCount);
        $finish;
    end

endmodule

// File: doc/mux_arbiter_2to1.md
MUX_ARBITER_2TO1 -- requirements
Module: mux_arbiter_2to1

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of each data beat.
REQ-002 SHALL have parameter MAX_BURST, default 16, maximum beats per grant (legal range 1..256).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports in0_valid, in1_valid  input  1 each  requester k presents a beat.
REQ-006 SHALL have ports in0_data, in1_data  input  DATA_WIDTH each  requester k beat data.
REQ-007 SHALL have ports in0_last, in1_last  input  1 each  final beat of requester k packet.
REQ-008 SHALL have ports in0_ready, in1_ready  output  1 each  beat of requester k accepted this cycle when valid also high.
REQ-009 SHALL have port out_valid  output  1  registered output beat valid.
REQ-010 SHALL have port out_data  output  DATA_WIDTH  registered output beat.
REQ-011 SHALL have port out_last  output  1  registered copy of accepted in_k_last.
REQ-012 SHALL have port out_src  output  1  index of requester that produced the current output beat.
REQ-013 SHALL have port out_ready  input  1  downstream accepts beat when out_valid also high.
REQ-014 SHALL have port sel  output  1  current grant, driven to the shared 2:1 data mux select.

Function
REQ-015 SHALL implement FSM states IDLE, GRANT0, GRANT1.
- IDLE: no ready asserted; on any in_k_valid, move to GRANTk next cycle (one-cycle arbitration latency).
- Both valid in IDLE: grant the requester not recorded in last_grant (round robin).
REQ-016 SHALL set sel to k on entry to GRANTk and hold sel unchanged in IDLE.
REQ-017 SHALL drive in_k_ready = 1 in GRANTk iff (!out_valid || out_ready); the non-granted ready SHALL be 0.
REQ-018 SHALL, on input handshake (in_k_valid && in_k_ready), load out_data, out_last, out_src=k and set out_valid=1 next cycle.
REQ-019 SHALL clear out_valid when out_ready && out_valid with no new input handshake in the same cycle.
REQ-020 SHALL count accepted beats in the current grant with a counter of ceil(log2(MAX_BURST+1)) bits, cleared on entry to GRANTk.
REQ-021 SHALL release the grant (next state IDLE, last_grant=k) on the handshake where in_k_last=1 or the count reaches MAX_BURST.
- Forced release SHALL not alter out_last; the remainder resumes under a later grant.
REQ-022 SHALL keep the grant while in_k_valid is low mid-packet (no timeout; no packet interleaving).
REQ-023 SHALL sustain one beat per cycle when out_ready stays high (full throughput, no bubbles inside a grant).
REQ-024 SHALL not change out_data, out_last, out_src while out_valid && !out_ready (output stable under backpressure).
REQ-025 SHALL insert exactly one idle output cycle (IDLE state) between consecutive grants.
REQ-026 SHALL with MAX_BURST=1 release after every beat, alternating strictly when both request.

Reset
REQ-027 SHALL on reset force state=IDLE, sel=0, last_grant=1, beat count=0, out_valid=0, out_last=0, out_src=0, out_data=0, both ready=0.
REQ-028 SHALL abort any packet on mid-operation reset; the partial packet is not resumed and no output beat is retained.
REQ-029 SHALL resume arbitration on the first rising edge after reset deasserts, with in0 winning a simultaneous request.

Verification
REQ-030 Both requesters valid after reset, 3-beat packets, out_ready=1 -> in0 beats A,B,C(last), one idle cycle, in1 beats, out_src 0,0,0 then 1,1,1.
REQ-031 in1 only, 4-beat packet, out_ready toggles 1,0,1,0 -> each beat held stable while out_ready=0, in1_ready low those cycles, no beat lost or duplicated.
REQ-032 MAX_BURST=4, in0 sends 6-beat packet while in1 valid -> 4 in0 beats, grant to in1 packet, then remaining 2 in0 beats; out_last only on in0 beat 6.
REQ-033 in0 mid-packet drops valid for 5 cycles while in1 valid -> grant stays 0, in1_ready=0, in0 resumes, in1 served after in0 last.
REQ-034 reset asserted asynchronously during GRANT1 beat 2 -> out_valid=0, sel=0, state IDLE immediately; after release in0 and in1 both valid -> in0 granted first.
REQ-035 MAX_BURST=1, both continuously valid -> sel alternates 0,1,0,1 with one idle cycle between beats.
